// File: rtl/uart_report_pkg.sv
// Shared constants, FSM state type and frame helpers for the sensor report arbiter.
package uart_report_pkg;

  localparam logic [7:0] HDR      = 8'hAA;
  localparam logic [7:0] ID_DHT11 = 8'h01;
  localparam logic [7:0] ID_SPO2  = 8'h02;
  localparam logic [7:0] ID_MQ2   = 8'h03;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [7:0] src_id(input logic [1:0] src);
    case (src)
      2'd0:    src_id = ID_DHT11;
      2'd1:    src_id = ID_SPO2;
      2'd2:    src_id = ID_MQ2;
      default: src_id = ID_DHT11;
    endcase
  endfunction

  function automatic logic [7:0] frame_chk(input logic [7:0] id, input logic [15:0] payload);
    frame_chk = id ^ payload[15:8] ^ payload[7:0];
  endfunction

endpackage

// File: rtl/uart_report_arbiter_rr_arb3.sv
// Three-way round-robin arbiter: search starts one past the most recent winner.
module rr_arb3
  import uart_report_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pend,
  input  logic       advance,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] last_r;

  // priority order rotated by the last winner
  always_comb begin
    winner = 2'd0;
    case (last_r)
      2'd0: begin
        if (pend[1])      winner = 2'd1;
        else if (pend[2]) winner = 2'd2;
        else if (pend[0]) winner = 2'd0;
        else              winner = 2'd1;
      end
      2'd1: begin
        if (pend[2])      winner = 2'd2;
        else if (pend[0]) winner = 2'd0;
        else if (pend[1]) winner = 2'd1;
        else              winner = 2'd2;
      end
      default: begin
        if (pend[0])      winner = 2'd0;
        else if (pend[1]) winner = 2'd1;
        else if (pend[2]) winner = 2'd2;
        else              winner = 2'd0;
      end
    endcase
  end

  assign valid = |pend;

  // pointer register
  always_ff @(posedge clk) begin
    if (rst)                   last_r <= 2'd2;
    else if (advance && valid) last_r <= winner;
    else                       last_r <= last_r;
  end

endmodule

// File: rtl/uart_report_arbiter.sv
// Latches posts from three sensor reporters and sends each as a 5-byte
// checksummed frame (AA, ID, MSB, LSB, CHK) over a valid/ready byte port.
module uart_report_arbiter
  import uart_report_pkg::*;
#(
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);

  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state_r, state_s;
  logic [15:0] hold_r [3];
  logic [2:0]  pend_r;
  logic [1:0]  win_s;
  logic        win_any_s;
  logic        gnt_en_s;
  logic [2:0]  win_oh_s, clr_s, ovr_s;
  logic [15:0] win_hold_s;
  logic [8:0]  ovr_sum_s;
  logic        last_acc_s;
  logic [7:0]  frm_id_r, frm_chk_r, ovr_r;
  logic [15:0] frm_pay_r;
  logic [2:0]  idx_r;
  logic [15:0] gap_r;
  logic [1:0]  grant_r;

  rr_arb3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .pend    (pend_r),
    .advance (gnt_en_s),
    .winner  (win_s),
    .valid   (win_any_s)
  );

  // grant-side decode: winner one-hot, its held value, and overrun detection
  always_comb begin
    gnt_en_s   = (state_r == IDLE) && win_any_s;
    last_acc_s = (state_r == SEND) && tx_ready && (idx_r == 3'd4);
    case (win_s)
      2'd0:    begin win_oh_s = 3'b001; win_hold_s = hold_r[0]; end
      2'd1:    begin win_oh_s = 3'b010; win_hold_s = hold_r[1]; end
      2'd2:    begin win_oh_s = 3'b100; win_hold_s = hold_r[2]; end
      default: begin win_oh_s = 3'b000; win_hold_s = 16'h0000; end
    endcase
    if (gnt_en_s) clr_s = win_oh_s;
    else          clr_s = 3'b000;
    ovr_s     = req & pend_r & ~clr_s;
    ovr_sum_s = {1'b0, ovr_r} + {8'd0, ovr_s[0]} + {8'd0, ovr_s[1]} + {8'd0, ovr_s[2]};
  end

  // hold/pend registers; a post in the grant cycle keeps pend set for a later frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hold_r[i] <= 16'h0000;
      pend_r <= 3'b000;
      ovr_r  <= 8'd0;
    end else begin
      hold_r[0] <= req[0] ? data0 : hold_r[0];
      hold_r[1] <= req[1] ? data1 : hold_r[1];
      hold_r[2] <= req[2] ? data2 : hold_r[2];
      pend_r    <= req | (pend_r & ~clr_s);
      ovr_r     <= ovr_sum_s[8] ? 8'hFF : ovr_sum_s[7:0];
    end
  end

  // frame snapshot, byte index and gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_id_r  <= 8'h00;
      frm_pay_r <= 16'h0000;
      frm_chk_r <= 8'h00;
      grant_r   <= 2'd0;
      idx_r     <= 3'd0;
      gap_r     <= 16'd0;
    end else begin
      if (gnt_en_s) begin
        frm_id_r  <= src_id(win_s);
        frm_pay_r <= win_hold_s;
        frm_chk_r <= frame_chk(src_id(win_s), win_hold_s);
        grant_r   <= win_s;
      end
      if (state_r == SEND && tx_ready) idx_r <= last_acc_s ? 3'd0 : idx_r + 3'd1;
      else if (state_r != SEND)        idx_r <= 3'd0;
      if (last_acc_s)                                 gap_r <= GAP_LOAD;
      else if (state_r == GAP && gap_r != 16'd0)      gap_r <= gap_r - 16'd1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_any_s) state_s = SEND;
        else           state_s = IDLE;
      end
      SEND: begin
        if (last_acc_s) state_s = (GAP_CYCLES > 0) ? GAP : IDLE;
        else            state_s = SEND;
      end
      GAP: begin
        if (gap_r == 16'd0) state_s = IDLE;
        else                state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // output decode from registered state and snapshot
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state_r == SEND) begin
      tx_valid = 1'b1;
      case (idx_r)
        3'd0:    tx_data = HDR;
        3'd1:    tx_data = frm_id_r;
        3'd2:    tx_data = frm_pay_r[15:8];
        3'd3:    tx_data = frm_pay_r[7:0];
        3'd4:    tx_data = frm_chk_r;
        default: tx_data = 8'h00;
      endcase
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
    busy       = (state_r != IDLE);
    frame_done = last_acc_s;
  end

  assign grant       = grant_r;
  assign overrun_cnt = ovr_r;

endmodule

// File: tb/tb_uart_report_arbiter.sv
// Directed bench for uart_report_arbiter: one instance with no gap, one with a 3-cycle gap.
`timescale 1ns/1ps
module tb_uart_report_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic        tx_ready;
  logic [7:0]  tx_data, overrun_cnt;
  logic        tx_valid, busy, frame_done;
  logic [1:0]  grant;
  logic [7:0]  g_tx_data, g_overrun_cnt;
  logic        g_tx_valid, g_busy, g_frame_done;
  logic [1:0]  g_grant;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  uart_report_arbiter #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .grant(grant), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  uart_report_arbiter #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(tx_ready), .busy(g_busy),
    .grant(g_grant), .frame_done(g_frame_done), .overrun_cnt(g_overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = 3'b000; tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic post(input int src, input logic [15:0] val);
    case (src)
      0:       data0 = val;
      1:       data1 = val;
      default: data2 = val;
    endcase
    req = 3'b000;
    req[src] = 1'b1;
    tick();
    req = 3'b000;
  endtask

  // collects the next five accepted bytes of the no-gap instance
  task automatic get_frame(input int limit, output logic [39:0] frm, output logic [4:0] fd,
                           output int t0, output int tl, output bit ok);
    int n;
    n = 0; frm = '0; fd = '0; t0 = -1; tl = -1;
    for (int k = 0; k < limit && n < 5; k++) begin
      @(negedge clk);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (n == 0) t0 = cyc;
        frm = {frm[31:0], tx_data};
        fd  = {fd[3:0], frame_done};
        tl  = cyc;
        n++;
      end
    end
    ok = (n == 5);
  endtask

  task automatic test_reset();
    bit seen;
    reset_dut();
    @(negedge clk);
    checks++; if ({tx_valid, busy, frame_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {tx_valid, busy, frame_done}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant !== 2'd0 || overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_grant_ovr: got %0d/%0d want 0/0", grant, overrun_cnt); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (tx_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_quiet: got tx_valid activity want none"); end
  endtask

  task automatic test_single();
    logic [39:0] f; logic [4:0] fd; int t0, tl, c; bit ok;
    reset_dut();
    c = cyc;
    post(1, 16'h1234);
    get_frame(20, f, fd, t0, tl, ok);
    checks++; if (!ok || f !== 40'hAA_02_12_34_24) begin errors++; $display("FAIL single_frame: got %h ok=%0d want aa02123424", f, ok); end
    checks++; if (fd !== 5'b00001) begin errors++; $display("FAIL single_done: got %b want 00001", fd); end
    checks++; if (t0 - c !== 2 || tl - t0 !== 4) begin errors++; $display("FAIL single_timing: got lat=%0d len=%0d want 2/4", t0 - c, tl - t0); end
    checks++; if (grant !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d want 1", grant); end
    checks++; if (g_frame_done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", g_frame_done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nogap_busy: got %b want 0", busy); end
    checks++; if (g_busy !== 1'b1) begin errors++; $display("FAIL gap_busy1: got %b want 1", g_busy); end
    repeat (2) @(negedge clk);
    checks++; if (g_busy !== 1'b1) begin errors++; $display("FAIL gap_busy3: got %b want 1", g_busy); end
    @(negedge clk);
    checks++; if (g_busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end: got %b want 0", g_busy); end
  endtask

  task automatic test_simultaneous();
    logic [39:0] f0, f1, f2; logic [4:0] fd; int a0, a1, a2, tl; bit ok0, ok1, ok2;
    int gr [3];
    reset_dut();
    gr[0] = -100; gr[1] = -200; gr[2] = -300;
    data0 = 16'h0A0B; data1 = 16'h1122; data2 = 16'hF00D; req = 3'b111;
    tick();
    req = 3'b000;
    fork
      begin
        get_frame(30, f0, fd, a0, tl, ok0);
        get_frame(30, f1, fd, a1, tl, ok1);
        get_frame(30, f2, fd, a2, tl, ok2);
      end
      begin
        logic prev; int nr;
        prev = 1'b0; nr = 0;
        repeat (40) begin
          @(negedge clk);
          if (g_tx_valid === 1'b1 && !prev && nr < 3) begin gr[nr] = cyc; nr++; end
          prev = g_tx_valid;
        end
      end
    join
    checks++; if (!ok0 || f0 !== 40'hAA_01_0A_0B_00) begin errors++; $display("FAIL sim_frame0: got %h want aa010a0b00", f0); end
    checks++; if (!ok1 || f1 !== 40'hAA_02_11_22_31) begin errors++; $display("FAIL sim_frame1: got %h want aa02112231", f1); end
    checks++; if (!ok2 || f2 !== 40'hAA_03_F0_0D_FE) begin errors++; $display("FAIL sim_frame2: got %h want aa03f00dfe", f2); end
    checks++; if (a1 - a0 !== 6 || a2 - a1 !== 6) begin errors++; $display("FAIL sim_spacing: got %0d,%0d want 6,6", a1 - a0, a2 - a1); end
    checks++; if (gr[1] - gr[0] !== 9 || gr[2] - gr[1] !== 9) begin errors++; $display("FAIL gap_spacing: got %0d,%0d want 9,9", gr[1] - gr[0], gr[2] - gr[1]); end
    checks++; if (grant !== 2'd2) begin errors++; $display("FAIL sim_grant: got %0d want 2", grant); end
  endtask

  task automatic test_backpressure();
    logic [39:0] f; logic [4:0] fd; int t0, tl; bit ok;
    reset_dut();
    post(2, 16'hBEEF);
    fork
      get_frame(40, f, fd, t0, tl, ok);
      begin
        int w;
        w = 0;
        do begin @(negedge clk); w++; end while (tx_valid !== 1'b1 && w < 20);
        checks++; if (w >= 20) begin errors++; $display("FAIL bp_start: got no tx_valid want frame start"); end
        tick(); tick();
        tx_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          checks++; if ({tx_valid, tx_data} !== 9'h1BE) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/be", tx_valid, tx_data); end
          tick();
        end
        tx_ready = 1'b1;
      end
    join
    checks++; if (!ok || f !== 40'hAA_03_BE_EF_52) begin errors++; $display("FAIL bp_frame: got %h want aa03beef52", f); end
    checks++; if (tl - t0 !== 14) begin errors++; $display("FAIL bp_length: got %0d want 14", tl - t0); end
  endtask

  task automatic test_overrun();
    logic [39:0] f1, f2; logic [4:0] fd; int t0, tl; bit ok1, ok2, seen;
    reset_dut();
    post(1, 16'h5555);
    fork
      begin
        get_frame(30, f1, fd, t0, tl, ok1);
        get_frame(30, f2, fd, t0, tl, ok2);
      end
      begin
        tick();
        post(0, 16'h0001);
        post(0, 16'h00FF);
      end
    join
    checks++; if (!ok1 || f1 !== 40'hAA_02_55_55_02) begin errors++; $display("FAIL ovr_frame1: got %h want aa02555502", f1); end
    checks++; if (!ok2 || f2 !== 40'hAA_01_00_FF_FE) begin errors++; $display("FAIL ovr_frame2: got %h want aa0100fffe", f2); end
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_count: got %0d want 1", overrun_cnt); end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (tx_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ovr_no_extra: got extra frame want none"); end
    data2 = 16'hABCD; req = 3'b100;
    repeat (400) tick();
    req = 3'b000;
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL ovr_saturate: got %0d want 255", overrun_cnt); end
  endtask

  task automatic test_collision();
    logic [39:0] f1, f2; logic [4:0] fd; int a0, a1, tl; bit ok1, ok2;
    reset_dut();
    post(0, 16'h1111);
    fork
      begin
        get_frame(30, f1, fd, a0, tl, ok1);
        get_frame(30, f2, fd, a1, tl, ok2);
      end
      post(0, 16'h2222);
    join
    checks++; if (!ok1 || f1 !== 40'hAA_01_11_11_01) begin errors++; $display("FAIL coll_old: got %h want aa01111101", f1); end
    checks++; if (!ok2 || f2 !== 40'hAA_01_22_22_01) begin errors++; $display("FAIL coll_new: got %h want aa01222201", f2); end
    checks++; if (a1 - a0 !== 6) begin errors++; $display("FAIL coll_spacing: got %0d want 6", a1 - a0); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL coll_ovr: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_dut();
    post(1, 16'h1234);
    post(2, 16'h0A0A);
    post(2, 16'h0B0B);
    @(negedge clk);
    checks++; if (overrun_cnt !== 8'd1 || tx_data !== 8'h02) begin errors++; $display("FAIL rm_pre: got ovr=%0d byte=%h want 1/02", overrun_cnt, tx_data); end
    tick(); tick();
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, tx_data} !== 9'h134) begin errors++; $display("FAIL rm_byte3: got %b/%h want 1/34", tx_valid, tx_data); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, busy} !== 2'b00 || overrun_cnt !== 8'd0) begin errors++; $display("FAIL rm_after: got v=%b b=%b ovr=%0d want 0/0/0", tx_valid, busy, overrun_cnt); end
    checks++; if (tx_data !== 8'h00 || grant !== 2'd0) begin errors++; $display("FAIL rm_outputs: got data=%h grant=%0d want 00/0", tx_data, grant); end
    tx_ready = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (tx_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_quiet: got frame after reset want none"); end
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; tx_ready = 1'b1;
    data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overrun();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_report_arbiter.md
# uart_report_arbiter

- Shares the single UART byte transmitter between the three sensor reporters: DHT11 temperature/humidity, MAX30102 SpO2, and MQ-2 gas status.
- Each reporter posts a 16-bit value with a one-cycle strobe. The block latches the value, picks a requester round-robin, and emits a 5-byte checksummed frame over a valid/ready byte interface.
- The frame goes to the UART serializer in front of `uart_tx`.
- The block sits inside `main`, between the sensor drivers and the UART byte transmitter.

## Interface
Parameters:
- `GAP_CYCLES`, default 16. Idle clocks enforced after each frame completes. Legal range 0–65535.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  3  per-source post strobes. Bit 0 is DHT11, bit 1 is SpO2, bit 2 is MQ-2.
- `data0`, `data1`, `data2`  in  16 each  payload for the matching source. Sampled only in cycles where that source's `req` bit is 1.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the transmitter accepts the byte.
- `busy`  out  1  high while a frame is being sent or a gap is running.
- `grant`  out  2  source of the current or most recent frame.
- `frame_done`  out  1  one-cycle pulse when the last byte of a frame is accepted.
- `overrun_cnt`  out  8  saturating count of posts that overwrote a not-yet-sent value.

## Operation
**Frame format.** Bytes in order:
- 0xAA
- ID: 0x01, 0x02 or 0x03 for source 0, 1 or 2
- payload[15:8]
- payload[7:0]
- CHK = ID ^ payload[15:8] ^ payload[7:0]

**Per-source hold logic.**
- `req[i]=1` loads `hold[i]` from `data_i` and sets `pend[i]`.
- If `pend[i]` was already 1 and is not being granted in the same cycle, `overrun_cnt` increments. It saturates at 255.
- Latest value wins.

**Arbitration.**
- Round-robin over `pend`. The search starts at source (`last`+1) mod 3.
- `last` resets to 2, so source 0 wins first after reset.
- On grant:
  - the winner's `hold` value is snapshotted into the frame register;
  - `pend[winner]` is cleared;
  - `grant` and `last` are updated.
- If `req[winner]` is high in the grant cycle:
  - the snapshot takes the pre-update `hold` value;
  - `pend` stays set, and the new value goes out in a later frame;
  - this case is not counted as an overrun.

**FSM states.**
- IDLE: if any `pend` bit is set, grant and go to SEND with byte index 0. Otherwise stay in IDLE.
- SEND:
  - `tx_valid`=1, and `tx_data` is the byte at the current index.
  - Advance the index only on `tx_valid & tx_ready`.
  - On acceptance of byte 4: pulse `frame_done`, then go to GAP (if `GAP_CYCLES`>0) or IDLE.
- GAP: count down `GAP_CYCLES` cycles, then go to IDLE.

**Output rules.**
- `busy` = (state != IDLE).
- `tx_data` and `tx_valid` must stay stable while `tx_ready`=0.

**Reset.** `rst`=1 forces the following on the next edge, including mid-frame:
- state = IDLE, `pend` = 0, `hold` = 0, `last` = 2;
- `tx_valid` = 0, `tx_data` = 0x00, `busy` = 0, `grant` = 0, `frame_done` = 0, `overrun_cnt` = 0.

A partially sent frame is abandoned. The downstream UART resynchronises on 0xAA.

## Timing
- `req` at edge t, then `pend` set at t+1, then grant and SEND entered at t+2, then byte 0 presented with `tx_valid`=1 at t+2.
- With `tx_ready` held at 1, one byte is accepted per cycle, in cycles t+2 through t+6.
- `frame_done` is high in cycle t+6, the cycle in which byte 4 is accepted. `busy` stays high through the GAP.
- Minimum spacing between byte 0 of consecutive frames is 5 + `GAP_CYCLES` + 1 cycles. The +1 is the IDLE grant cycle.
- Checksum is computed at snapshot time, so there is no added latency.

## Structure
- Shared package `uart_report_pkg` holds:
  - `HDR` = 8'hAA;
  - source ID constants `ID_DHT11`, `ID_SPO2`, `ID_MQ2`;
  - the FSM state enum {IDLE, SEND, GAP}.
- One sub-module, `rr_arb3`: 3-way round-robin grant from `pend` plus the `last` pointer. It is purely combinational apart from the `last` register.

## Test plan
- Single post: `req[1]`, `data1`=0x1234, `tx_ready`=1 → bytes AA 02 12 34 24 in consecutive cycles, `frame_done` on the 5th byte, `grant`=1.
- Simultaneous post of all three just after reset, `GAP_CYCLES`=0 → frames in order ID 01, 02, 03. Spacing between the header bytes is exactly 6 cycles.
- Back-pressure: drop `tx_ready` for 10 cycles while byte 2 is presented → `tx_data` and `tx_valid` are unchanged throughout, and the frame completes correctly afterwards.
- Overrun: while a source-1 frame is sending, post source 0 twice, with 0x0001 then 0x00FF → one source-0 frame carrying payload 0x00FF, and `overrun_cnt`=1.
- Grant-cycle collision: `req[0]` asserted in source 0's grant cycle with a new value → the current frame carries the old value, and a second frame carries the new one.
- Reset mid-frame: assert `rst` while byte 3 is pending → next cycle `tx_valid`=0, `busy`=0, `overrun_cnt`=0. No frame follows unless a new `req` arrives.
